// File: rtl/cfi_pkg.sv
// rtl/cfi_pkg.sv - shared types and constants for the CFI violation reporter
package cfi_pkg;

  // Width of the stored PC; the reporter's XLEN must not exceed this.
  localparam int unsigned CFI_PC_W = 64;

  // Software-check exception code raised towards the controller/CSRs.
  localparam int unsigned CFI_EXC_CODE = 18;

  typedef enum logic [1:0] {
    NONE         = 2'd0,
    JALR_NO_LP   = 2'd1,
    RET_MISMATCH = 2'd2,
    BAD_TARGET   = 2'd3
  } cfi_cause_e;

  typedef struct packed {
    logic [CFI_PC_W-1:0] pc;
    cfi_cause_e          cause;
  } cfi_viol_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_REPORT = 2'b01,
    ST_HALT   = 2'b10
  } cfi_rep_state_e;

endpackage

// File: rtl/cfi_viol_fifo.sv
// rtl/cfi_viol_fifo.sv - small FIFO of violation records with extra-bit pointers
module cfi_viol_fifo
  import cfi_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear,
  input  logic                     push,
  input  cfi_viol_t                wdata,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output cfi_viol_t                head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  cfi_viol_t   mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  // Advance pointers on push/pop; clear flushes everything at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; only entries between the pointers are ever read out.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/cfi_violation_reporter.sv
// rtl/cfi_violation_reporter.sv - buffers CFI violation reports and raises them as exceptions
module cfi_violation_reporter
  import cfi_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             halt_on_viol_i,
  input  logic             clear_i,
  input  logic             viol_valid_i,
  input  logic [XLEN-1:0]  viol_pc_i,
  input  logic [1:0]       viol_cause_i,
  output logic             viol_ready_o,
  output logic             ex_valid_o,
  output logic [XLEN-1:0]  ex_cause_o,
  output logic [XLEN-1:0]  ex_tval_o,
  output logic [1:0]       ex_subcause_o,
  input  logic             ex_ack_i,
  output logic             halt_o,
  output logic [CNT_W-1:0] viol_count_o,
  output logic             overflow_o,
  output logic [1:0]       state_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic           full;
  logic           empty;
  logic [AW:0]    occupancy;
  cfi_viol_t      wdata;
  cfi_viol_t      head;
  logic           push;
  logic           drop;
  logic           pop;
  logic           remain;

  cfi_rep_state_e state;
  logic           ex_valid;
  logic           halt;
  logic [CNT_W-1:0] count;
  logic           overflow;

  // Ready depends only on registered occupancy; when disabled, reports are sunk.
  assign viol_ready_o = enable_i ? !full : 1'b1;

  assign push = viol_valid_i && enable_i && !full && !clear_i;
  assign drop = viol_valid_i && enable_i && full && !clear_i;
  assign pop  = ex_valid && ex_ack_i && !clear_i;

  // After popping the head, something is still left to report (incl. a same-cycle push).
  assign remain = (occupancy != (AW+1)'(1)) || push;

  assign wdata.pc    = CFI_PC_W'(viol_pc_i);
  assign wdata.cause = cfi_cause_e'(viol_cause_i);

  cfi_viol_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear  (clear_i),
    .push   (push),
    .wdata  (wdata),
    .pop    (pop),
    .full   (full),
    .empty  (empty),
    .head   (head),
    .count  (occupancy)
  );

  // Request payload comes straight from the FIFO head, which cannot move until acked.
  assign ex_valid_o    = ex_valid;
  assign ex_cause_o    = ex_valid ? XLEN'(CFI_EXC_CODE) : '0;
  assign ex_tval_o     = ex_valid ? XLEN'(head.pc) : '0;
  assign ex_subcause_o = ex_valid ? head.cause : 2'b00;
  assign halt_o        = halt;
  assign viol_count_o  = count;
  assign overflow_o    = overflow;
  assign state_o       = state;

  // Reporting FSM with registered request/halt outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= ST_IDLE;
      ex_valid <= 1'b0;
      halt     <= 1'b0;
    end else if (clear_i) begin
      state    <= ST_IDLE;
      ex_valid <= 1'b0;
      halt     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // A push this cycle is visible at the head next cycle, so raise with it.
          if (!empty || push) begin
            state    <= ST_REPORT;
            ex_valid <= 1'b1;
          end
        end
        ST_REPORT: begin
          if (ex_ack_i) begin
            if (halt_on_viol_i) begin
              state    <= ST_HALT;
              ex_valid <= 1'b0;
              halt     <= 1'b1;
            end else if (!remain) begin
              state    <= ST_IDLE;
              ex_valid <= 1'b0;
            end
          end
        end
        ST_HALT: begin
          ex_valid <= 1'b0;
          halt     <= 1'b1;
        end
        default: begin
          state    <= ST_IDLE;
          ex_valid <= 1'b0;
          halt     <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of every accepted or dropped report.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count <= '0;
    end else if (clear_i) begin
      count <= '0;
    end else if ((push || drop) && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

  // Sticky flag recording that at least one report was lost to a full FIFO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow <= 1'b0;
    end else if (clear_i) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: doc/cfi_violation_reporter.md
Name: cfi_violation_reporter

Overview:
- Consumer end of the commit-stage CFI checker's violation interface.
- Accepts violation reports (PC + cause) through a valid/ready handshake and buffers them in a small FIFO.
- Raises each buffered report, one at a time, as a software-check exception request to the controller/CSR side, using a req/ack handshake.
- Keeps a saturating violation counter and a sticky overflow flag. Optionally halts after the first reported violation.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- XLEN, 64, PC / tval width.
- CNT_W, 16, violation counter width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- enable_i  in  1  block enable; when 0, reports are sunk and ignored
- halt_on_viol_i  in  1  enter HALT after the first acknowledged report
- clear_i  in  1  sync clear: FIFO, counter, overflow, state
- viol_valid_i  in  1  violation report valid
- viol_pc_i  in  XLEN  PC of the offending instruction
- viol_cause_i  in  2  cfi_cause_e code
- viol_ready_o  out  1  report accepted
- ex_valid_o  out  1  exception request
- ex_cause_o  out  XLEN  exception cause (CFI_EXC_CODE, interrupt bit 0)
- ex_tval_o  out  XLEN  offending PC
- ex_subcause_o  out  2  cfi_cause_e of the head entry
- ex_ack_i  in  1  exception taken
- halt_o  out  1  core halt request
- viol_count_o  out  CNT_W  saturating count of detected violations
- overflow_o  out  1  sticky; a report was dropped
- state_o  out  2  FSM state, for debug

Behaviour:
- Reset: clock clk_i; reset rst_ni, asynchronous, active-low. During reset: FIFO empty, state IDLE, ex_valid_o=0, halt_o=0, viol_count_o=0, overflow_o=0, ex_cause_o/ex_tval_o/ex_subcause_o=0.
- viol_ready_o = enable_i ? !full : 1. It is registered-state only, with no combinational path from ex_ack_i.
- Push: viol_valid_i & viol_ready_o & enable_i & !clear_i. A push in cycle N makes the entry visible at the FIFO head in cycle N+1.
- Drop: viol_valid_i & enable_i & full & !clear_i. The entry is discarded, overflow_o is set and stays set until clear_i.
- Counter: increments on every push and every drop. It saturates at all-ones and never wraps. Reports arriving while enable_i=0 are not counted.
- Simultaneous push and pop: allowed when not full; occupancy is unchanged. Pointers wrap modulo DEPTH. A full/empty distinction uses an extra pointer bit.
- FSM states:
  - IDLE (00): ex_valid_o=0. Goes to REPORT when the FIFO is not empty.
  - REPORT (01): ex_valid_o=1. ex_cause_o, ex_tval_o and ex_subcause_o are driven from the FIFO head and are stable while ex_valid_o=1 and ex_ack_i=0. On ex_ack_i the entry is popped; then:
    - if halt_on_viol_i=1, go to HALT;
    - else, if the FIFO is still non-empty, stay in REPORT with ex_valid_o held high and the next entry presented the following cycle;
    - else, go to IDLE.
  - HALT (10): halt_o=1, ex_valid_o=0. Pushes, drops and counting continue. The only exit is clear_i.
- ex_ack_i while ex_valid_o=0 is ignored.
- clear_i has priority over everything: FIFO flushed, counter=0, overflow_o=0, state IDLE, ex_valid_o=0, halt_o=0 the next cycle. A push in the same cycle is dropped and not counted. halt_on_viol_i is sampled only on ack.
- enable_i falling while in REPORT: the pending request stays until acked. No new reports are accepted.
- Asynchronous reset mid-handshake: the request is abandoned and all state goes to its reset values.

Decomposition:
- cfi_pkg holds:
  - cfi_cause_e: NONE=0, JALR_NO_LP=1, RET_MISMATCH=2, BAD_TARGET=3;
  - CFI_EXC_CODE=18;
  - cfi_viol_t {pc, cause};
  - cfi_rep_state_e.
- Sub-module cfi_viol_fifo (DEPTH, cfi_viol_t entries) provides push/pop/full/empty/head.

Test Plan:
- Single report: pc=0x8000_0040, cause=1, ack held low 3 cycles → ex_valid_o=1 from N+1, tval stable at 0x8000_0040, subcause=1; after ack, IDLE, count=1.
- Back-to-back: 3 reports in consecutive cycles, ack each immediately → three requests in order, ex_valid_o continuous, count=3, overflow_o=0.
- Overflow: DEPTH=4, 6 reports with ack held low → viol_ready_o=0 after 4, overflow_o=1, count=6; after 4 acks, exactly 4 PCs reported in push order.
- Halt: halt_on_viol_i=1, 2 reports → first acked, halt_o=1, second not raised; clear_i → IDLE, count=0, FIFO empty.
- Collision: clear_i and viol_valid_i in the same cycle → nothing stored, count=0; a push and an ack in the same cycle with 2 entries keeps occupancy at 2.
- Saturation and reset: CNT_W=4, 20 reports → count=15. Asserting rst_ni low mid-REPORT zeroes all outputs.
